// File: rtl/bus_device_port.sv
// rtl/bus_device_port.sv - device-side bus endpoint: TX/RX FWFT FIFOs with RX address filter
// Error counters saturate; FIFO outputs read as zero while their FIFO is empty.

module bus_device_port_fifo #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr,
    input  logic [width-1:0]         i_data,
    input  logic                     i_rd,
    output logic [width-1:0]         o_head,
    output logic [$clog2(depth):0]   o_count
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && i_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_wr, i_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
endmodule

module bus_device_port #(
    parameter int         pckg_sz   = 32,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         cnt_w     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [pckg_sz-1:0]       tx_data,
    output logic                     pndng,
    input  logic                     pop,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [pckg_sz-1:0]       rx_data,
    output logic [$clog2(depth):0]   tx_count,
    output logic [$clog2(depth):0]   rx_count,
    output logic [cnt_w-1:0]         drop_cnt,
    output logic [cnt_w-1:0]         misaddr_cnt
);
    localparam int               CW   = $clog2(depth) + 1;
    localparam logic [CW-1:0]    FULL = CW'(depth);

    logic [CW-1:0]      w_tx_count;
    logic [CW-1:0]      w_rx_count;
    logic [pckg_sz-1:0] w_tx_head;
    logic [pckg_sz-1:0] w_rx_head;
    logic               w_tx_ready;
    logic               w_pndng;
    logic               w_rx_valid;
    logic               w_tx_wr;
    logic               w_tx_rd;
    logic               w_rx_wr;
    logic               w_rx_rd;
    logic [7:0]         w_dest;
    logic               w_match;
    logic               w_drop;
    logic               w_misaddr;
    logic [cnt_w-1:0]   r_drop_cnt;
    logic [cnt_w-1:0]   r_misaddr_cnt;

    assign w_tx_ready = (w_tx_count != FULL);
    assign w_pndng    = (w_tx_count != '0);
    assign w_rx_valid = (w_rx_count != '0);

    // A TX write while full is refused even if pop frees a slot this cycle.
    assign w_tx_wr = tx_valid && w_tx_ready;
    assign w_tx_rd = pop && w_pndng;

    assign w_dest    = D_push[pckg_sz-1:pckg_sz-8];
    assign w_match   = (w_dest == id) || (w_dest == broadcast);
    assign w_rx_rd   = rx_valid && rx_ready;
    // A full RX FIFO still accepts a matching push when the host frees the head.
    assign w_rx_wr   = push && w_match && ((w_rx_count != FULL) || w_rx_rd);
    assign w_drop    = push && w_match && !w_rx_wr;
    assign w_misaddr = push && !w_match;

    bus_device_port_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (w_tx_wr),
        .i_data  (tx_data),
        .i_rd    (w_tx_rd),
        .o_head  (w_tx_head),
        .o_count (w_tx_count)
    );

    bus_device_port_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (w_rx_wr),
        .i_data  (D_push),
        .i_rd    (w_rx_rd),
        .o_head  (w_rx_head),
        .o_count (w_rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt    <= '0;
            r_misaddr_cnt <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_misaddr && (r_misaddr_cnt != '1)) begin
                r_misaddr_cnt <= r_misaddr_cnt + 1'b1;
            end
        end
    end

    assign tx_ready    = w_tx_ready;
    assign pndng       = w_pndng;
    assign D_pop       = w_tx_head;
    assign rx_valid    = w_rx_valid;
    assign rx_data     = w_rx_head;
    assign tx_count    = w_tx_count;
    assign rx_count    = w_rx_count;
    assign drop_cnt    = r_drop_cnt;
    assign misaddr_cnt = r_misaddr_cnt;
endmodule

// File: tb/tb_bus_device_port.sv
// tb/tb_bus_device_port.sv - self-checking bench for bus_device_port
module tb_bus_device_port;
    localparam int         W     = 32;
    localparam int         D     = 8;
    localparam int         CW    = 4;
    localparam int         CNTW  = 16;
    localparam logic [7:0] MY_ID = 8'd2;
    localparam logic [7:0] BCAST = 8'hFF;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic [W-1:0]    tx_data = '0;
    logic            pndng;
    logic            pop = 1'b0;
    logic [W-1:0]    d_pop;
    logic            push = 1'b0;
    logic [W-1:0]    d_push = '0;
    logic            rx_valid;
    logic            rx_ready = 1'b0;
    logic [W-1:0]    rx_data;
    logic [CW-1:0]   tx_count;
    logic [CW-1:0]   rx_count;
    logic [CNTW-1:0] drop_cnt;
    logic [CNTW-1:0] misaddr_cnt;

    bus_device_port #(
        .pckg_sz   (W),
        .depth     (D),
        .id        (MY_ID),
        .broadcast (BCAST),
        .cnt_w     (CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .pndng       (pndng),
        .pop         (pop),
        .D_pop       (d_pop),
        .push        (push),
        .D_push      (d_push),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .drop_cnt    (drop_cnt),
        .misaddr_cnt (misaddr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues and integer counters.
    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    int           m_drop = 0;
    int           m_mis  = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit tx_wr, tx_rd, rx_rd, accept;
        logic [7:0] dest;
        if (reset) begin
            m_tx.delete();
            m_rx.delete();
            m_drop = 0;
            m_mis  = 0;
        end else begin
            tx_wr = tx_valid && (m_tx.size() < D);
            tx_rd = pop && (m_tx.size() > 0);
            if (tx_rd) void'(m_tx.pop_front());
            if (tx_wr) m_tx.push_back(tx_data);
            rx_rd  = rx_ready && (m_rx.size() > 0);
            accept = 1'b0;
            dest   = d_push[31:24];
            if (push) begin
                if (dest == MY_ID || dest == BCAST) begin
                    if (m_rx.size() < D || rx_rd) accept = 1'b1;
                    else if (m_drop < 65535) m_drop++;
                end else if (m_mis < 65535) begin
                    m_mis++;
                end
            end
            if (rx_rd) void'(m_rx.pop_front());
            if (accept) m_rx.push_back(d_push);
        end
    endtask

    task automatic model_check();
        n_vec++;
        chk("tx_count",    32'(tx_count),    32'(m_tx.size()));
        chk("rx_count",    32'(rx_count),    32'(m_rx.size()));
        chk("tx_ready",    32'(tx_ready),    32'(m_tx.size() < D));
        chk("pndng",       32'(pndng),       32'(m_tx.size() > 0));
        chk("rx_valid",    32'(rx_valid),    32'(m_rx.size() > 0));
        chk("d_pop",       d_pop,            (m_tx.size() > 0) ? m_tx[0] : 32'h0);
        chk("rx_data",     rx_data,          (m_rx.size() > 0) ? m_rx[0] : 32'h0);
        chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
        chk("misaddr_cnt", 32'(misaddr_cnt), 32'(m_mis));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic drive(input logic r, input logic tv, input logic [31:0] td, input logic pp,
                         input logic ps, input logic [31:0] dp, input logic rr);
        reset = r; tx_valid = tv; tx_data = td; pop = pp; push = ps; d_push = dp; rx_ready = rr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        idle();
    endtask

    typedef struct {
        logic        rst;
        logic        tv;
        logic [31:0] td;
        logic        pp;
        logic        ps;
        logic [31:0] dp;
        logic        rr;
        logic [3:0]  e_txc;
        logic [3:0]  e_rxc;
        logic        e_pndng;
        logic [31:0] e_dpop;
        logic [31:0] e_rxd;
        logic [15:0] e_drop;
        logic [15:0] e_mis;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0};
        tbl[1]  = tbl[0];
        tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h020000AA, 1'b0, 4'd0, 4'd1, 1'b0, 32'h0, 32'h020000AA, 16'd0, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFF0000BB, 1'b0, 4'd0, 4'd2, 1'b0, 32'h0, 32'h020000AA, 16'd0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h050000CC, 1'b0, 4'd0, 4'd2, 1'b0, 32'h0, 32'h020000AA, 16'd0, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd1, 1'b0, 32'h0, 32'hFF0000BB, 16'd0, 16'd1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd1};
        tbl[7]  = tbl[6];
        tbl[8]  = '{1'b0, 1'b1, 32'h02000001, 1'b0, 1'b0, 32'h0, 1'b0, 4'd1, 4'd0, 1'b1, 32'h02000001, 32'h0, 16'd0, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd1};
        tbl[10] = tbl[9];
        tbl[11] = '{1'b0, 1'b1, 32'h02000002, 1'b1, 1'b0, 32'h0, 1'b0, 4'd1, 4'd0, 1'b1, 32'h02000002, 32'h0, 16'd0, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 32'h02000003, 1'b1, 1'b0, 32'h0, 1'b0, 4'd1, 4'd0, 1'b1, 32'h02000003, 32'h0, 16'd0, 16'd1};

        // Table vectors: reset, RX filtering, empty reads/pops, TX write/pop overlap.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].tv, tbl[i].td, tbl[i].pp, tbl[i].ps, tbl[i].dp, tbl[i].rr);
            step();
            chk($sformatf("tbl%0d.tx_count", i), 32'(tx_count), 32'(tbl[i].e_txc));
            chk($sformatf("tbl%0d.rx_count", i), 32'(rx_count), 32'(tbl[i].e_rxc));
            chk($sformatf("tbl%0d.pndng", i), 32'(pndng), 32'(tbl[i].e_pndng));
            chk($sformatf("tbl%0d.d_pop", i), d_pop, tbl[i].e_dpop);
            chk($sformatf("tbl%0d.rx_data", i), rx_data, tbl[i].e_rxd);
            chk($sformatf("tbl%0d.drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
            chk($sformatf("tbl%0d.misaddr_cnt", i), 32'(misaddr_cnt), 32'(tbl[i].e_mis));
        end

        // Reset held two cycles, then idle state.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        idle();
        chk("rst.pndng", 32'(pndng), 32'd0);
        chk("rst.tx_ready", 32'(tx_ready), 32'd1);
        chk("rst.rx_valid", 32'(rx_valid), 32'd0);
        chk("rst.d_pop", d_pop, 32'h0);

        // TX fill, refused 9th write, drain in order, ignored pop.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, 32'h02000000 + 32'(k), 1'b0, 1'b0, 32'h0, 1'b0);
            step();
        end
        chk("fill.tx_count", 32'(tx_count), 32'd8);
        chk("fill.tx_ready", 32'(tx_ready), 32'd0);
        drive(1'b0, 1'b1, 32'h02000009, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("full_write.tx_count", 32'(tx_count), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            chk("drain.d_pop", d_pop, 32'h02000000 + 32'(k));
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
        end
        chk("drain.pndng", 32'(pndng), 32'd0);
        step();
        chk("extra_pop.tx_count", 32'(tx_count), 32'd0);

        // Simultaneous write+pop at count 3 across pointer wrap.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b1, 32'h03000000 + 32'(k), 1'b0, 1'b0, 32'h0, 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            chk("wrap.d_pop", d_pop, 32'h03000001 + 32'(i));
            drive(1'b0, 1'b1, 32'h03000004 + 32'(i), 1'b1, 1'b0, 32'h0, 1'b0);
            step();
            chk("wrap.tx_count", 32'(tx_count), 32'd3);
        end
        idle();

        // RX overflow: drop when full, accept when full with simultaneous read.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h02000000 + 32'(k), 1'b0);
            step();
        end
        chk("rxfull.rx_count", 32'(rx_count), 32'd8);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h02000009, 1'b0);
        step();
        chk("overflow.drop_cnt", 32'(drop_cnt), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0200000A, 1'b1);
        step();
        chk("full_rw.rx_count", 32'(rx_count), 32'd8);
        for (int j = 0; j < 8; j++) begin
            chk("rx_order", rx_data, (j < 7) ? 32'h02000002 + 32'(j) : 32'h0200000A);
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            step();
        end
        chk("rx_drained", 32'(rx_valid), 32'd0);

        // Mid-operation reset with tx=5, rx=3, drop=2; push during reset ignored.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b1, 32'h04000000 + 32'(k), 1'b0, 1'b0, 32'h0, 1'b0);
            step();
        end
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFF000000 + 32'(k), 1'b0);
            step();
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            step();
        end
        chk("pre_rst.tx_count", 32'(tx_count), 32'd5);
        chk("pre_rst.rx_count", 32'(rx_count), 32'd3);
        chk("pre_rst.drop_cnt", 32'(drop_cnt), 32'd2);
        drive(1'b1, 1'b1, 32'h04000099, 1'b1, 1'b1, 32'h020000EE, 1'b1);
        step();
        chk("mid_rst.tx_count", 32'(tx_count), 32'd0);
        chk("mid_rst.rx_count", 32'(rx_count), 32'd0);
        chk("mid_rst.drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mid_rst.rx_data", rx_data, 32'h0);
        idle();
        step();
        chk("post_rst.rx_valid", 32'(rx_valid), 32'd0);
        chk("post_rst.misaddr_cnt", 32'(misaddr_cnt), 32'd0);

        // Randomized traffic against the queue model, with phases biasing fill/drain.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int phase;
            logic [7:0] dest;
            phase = (i / 250) % 2;
            case ($urandom_range(0, 3))
                0:       dest = MY_ID;
                1:       dest = BCAST;
                2:       dest = 8'h05;
                default: dest = 8'h00;
            endcase
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) < (phase ? 3 : 8)),
                  $urandom,
                  ($urandom_range(0, 9) < (phase ? 8 : 3)),
                  ($urandom_range(0, 9) < (phase ? 8 : 4)),
                  {dest, 24'($urandom)},
                  ($urandom_range(0, 9) < (phase ? 2 : 7)));
            step();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
